cla_pipe_addsub: RTL

Parametrised, pipelined carry-lookahead adder/subtractor for the FP ALU mantissa datapath. It splits a WIDTH-bit operation into NSEG = WIDTH/SEG_W lookahead segments. Each segment has its own register stage, and the carry is pipelined between stages. Operands enter and results leave through a valid/ready handshake with full-pipe stall, so the block can sit between the alignment shifter and the normaliser at mantissa widths of 24, 48 or 53 and above.

---
 rtl/cla_pkg.sv | 20 ++
 rtl/cla_seg.sv | 46 ++++
 rtl/cla_pipe_addsub.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// mode encoding, segment-count helper and the per-stage valid/tag record.
package cla_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Widest sideband tag a stage record can carry; narrower tags are zero-extended.
   localparam int unsigned TAG_W_MAX = 16;

   typedef struct packed {
      logic                 valid;
      logic [TAG_W_MAX-1:0] tag;
   } stage_rec_t;

   function automatic int unsigned nseg(input int unsigned width, input int unsigned seg_w);
      return (seg_w == 0) ? 0 : width / seg_w;
   endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG_W-bit carry-lookahead segment. Also exposes the carry
// into the segment MSB so the top can derive signed overflow.
module cla_seg
   import cla_pkg::*;
#(
   parameter int unsigned SEG_W = 8
) (
   input  logic [SEG_W-1:0] a,
   input  logic [SEG_W-1:0] b,
   input  logic             ci,
   output logic [SEG_W-1:0] s,
   output logic             co,
   output logic             msb_ci
);

   logic [SEG_W-1:0] g;
   logic [SEG_W-1:0] p;
   logic [SEG_W:0]   c;
   logic             run_p;
   logic             acc;

   assign g = a & b;
   assign p = a ^ b;

   // Each carry is a flat sum of generate terms gated by the propagate run above them.
   always_comb begin
      c     = '0;
      run_p = 1'b0;
      acc   = 1'b0;
      c[0]  = ci;
      for (int i = 0; i < SEG_W; i++) begin
         run_p = 1'b1;
         acc   = 1'b0;
         for (int j = i; j >= 0; j--) begin
            acc   = acc | (g[j] & run_p);
            run_p = run_p & p[j];
         end
         c[i+1] = acc | (run_p & ci);
      end
   end

   assign s      = p ^ c[SEG_W-1:0];
   assign co     = c[SEG_W];
   assign msb_ci = c[SEG_W-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor, one register stage per segment,
// valid/ready handshake with full-pipe stall. Define CLA_PIPE_FLAGS_EN to add zero/ovf outputs.
module cla_pipe_addsub
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned SEG_W = 8,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic [TAG_W-1:0] out_tag
`ifdef CLA_PIPE_FLAGS_EN
   ,
   output logic             zero,
   output logic             ovf
`endif
);

   localparam int unsigned NSEG = nseg(WIDTH, SEG_W);

   if (SEG_W < 1 || (WIDTH % SEG_W) != 0 || TAG_W < 1 || TAG_W > TAG_W_MAX) begin : g_param_err
      $error("cla_pipe_addsub: WIDTH must be a non-zero multiple of SEG_W and TAG_W within 1..TAG_W_MAX");
   end

   logic             advance_c;
   logic [WIDTH-1:0] b_x;
   logic             ci_x;
   stage_rec_t       last_rec;

   assign advance_c = ~(out_valid & ~out_ready);
   assign in_ready  = advance_c;

   assign b_x  = (sub == MODE_ADD) ? b : ~b;
   assign ci_x = (sub == MODE_SUB) ? 1'b1 : c_in;

   for (genvar k = 0; k < NSEG; k++) begin : g_stg
      // Operand bits still to be summed as they arrive at this stage.
      localparam int unsigned REM_IN = WIDTH - k * SEG_W;

      logic [REM_IN-1:0]      a_in;
      logic [REM_IN-1:0]      b_in;
      logic                   ci_in;
      stage_rec_t             rec_d;
      stage_rec_t             rec_q;
      logic [(k+1)*SEG_W-1:0] sum_d;
      logic [(k+1)*SEG_W-1:0] sum_q;
      logic [SEG_W-1:0]       seg_s;
      logic                   seg_co;
      logic                   seg_msb_ci;
      logic                   c_q;

      if (k == 0) begin : g_first
         assign a_in      = a;
         assign b_in      = b_x;
         assign ci_in     = ci_x;
         assign rec_d.valid = in_valid;
         assign rec_d.tag   = TAG_W_MAX'(in_tag);
         assign sum_d     = seg_s;
      end else begin : g_next
         assign a_in  = g_stg[k-1].g_op.a_q;
         assign b_in  = g_stg[k-1].g_op.b_q;
         assign ci_in = g_stg[k-1].c_q;
         assign rec_d = g_stg[k-1].rec_q;
         assign sum_d = {seg_s, g_stg[k-1].sum_q};
      end

      cla_seg #(.SEG_W(SEG_W)) u_seg (
         .a      (a_in[SEG_W-1:0]),
         .b      (b_in[SEG_W-1:0]),
         .ci     (ci_in),
         .s      (seg_s),
         .co     (seg_co),
         .msb_ci (seg_msb_ci)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rec_q <= '0;
            sum_q <= '0;
            c_q   <= 1'b0;
         end else if (advance_c) begin
            rec_q <= rec_d;
            sum_q <= sum_d;
            c_q   <= seg_co;
         end
      end

      // Skew registers: upper segments ride along until their carry catches up.
      if (k < NSEG - 1) begin : g_op
         logic [REM_IN-SEG_W-1:0] a_q;
         logic [REM_IN-SEG_W-1:0] b_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (advance_c) begin
               a_q <= a_in[REM_IN-1:SEG_W];
               b_q <= b_in[REM_IN-1:SEG_W];
            end
         end
      end

`ifdef CLA_PIPE_FLAGS_EN
      if (k == NSEG - 1) begin : g_flags
         logic zero_q;
         logic ovf_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               zero_q <= 1'b0;
               ovf_q  <= 1'b0;
            end else if (advance_c) begin
               zero_q <= (sum_d == '0);
               ovf_q  <= seg_msb_ci ^ seg_co;
            end
         end
      end else begin : g_msb_sink
         logic unused_msb_ci;
         assign unused_msb_ci = seg_msb_ci;
      end
`else
      logic unused_msb_ci;
      assign unused_msb_ci = seg_msb_ci;
`endif
   end

   assign last_rec  = g_stg[NSEG-1].rec_q;
   assign out_valid = last_rec.valid;
   assign out_tag   = last_rec.tag[TAG_W-1:0];
   assign s         = g_stg[NSEG-1].sum_q;
   assign c_out     = g_stg[NSEG-1].c_q;

`ifdef CLA_PIPE_FLAGS_EN
   assign zero = g_stg[NSEG-1].g_flags.zero_q;
   assign ovf  = g_stg[NSEG-1].g_flags.ovf_q;
`endif

   if (TAG_W < TAG_W_MAX) begin : g_tag_sink
      logic unused_tag_hi;
      assign unused_tag_hi = |last_rec.tag[TAG_W_MAX-1:TAG_W];
   end

endmodule
